// File: rtl/gate_tt_sweeper_if.sv
// Host/gate bundle for gate_tt_sweeper; optional mismatch-report signals under GATE_SWEEP_MISMATCH_EN.
// slave = sweeper side, master = host plus gate-under-test side.
interface gate_tt_sweeper_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] tt_captured;
    logic [3:0]  gate_in;
    logic        gate_out;
`ifdef GATE_SWEEP_MISMATCH_EN
    logic        first_mm_valid;
    logic [3:0]  first_mm_idx;

    modport slave  (input start, gate_out,
                    output busy, done, pass, tt_captured, gate_in, first_mm_valid, first_mm_idx);
    modport master (output start, gate_out,
                    input busy, done, pass, tt_captured, gate_in, first_mm_valid, first_mm_idx);
`else
    modport slave  (input start, gate_out,
                    output busy, done, pass, tt_captured, gate_in);
    modport master (output start, gate_out,
                    input busy, done, pass, tt_captured, gate_in);
`endif
endinterface

// File: rtl/gate_tt_sweeper.sv
// Sweeps all 16 vectors through a 4-input gate, captures its truth table and compares to EXPECTED_TT.
// Latency: done 16*(SETTLE_CYCLES+1)+1 cycles after start; start ignored while busy. Macro GATE_SWEEP_MISMATCH_EN adds first-mismatch report.
module gate_tt_sweeper #(
    parameter logic [15:0] EXPECTED_TT   = 16'h1CBF,
    parameter int          SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    gate_tt_sweeper_if.slave bus
);
    typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [15:0] tt_q, tt_d;
    logic        mm_vld_q, mm_vld_d;
    logic [3:0]  mm_idx_q, mm_idx_d;

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        tt_d     = tt_q;
        mm_vld_d = mm_vld_q;
        mm_idx_d = mm_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d  = APPLY;
                    vec_d    = 4'd0;
                    cnt_d    = CNT_RELOAD;
                    busy_d   = 1'b1;
                    pass_d   = 1'b0;
                    tt_d     = 16'h0000;
                    mm_vld_d = 1'b0;
                    mm_idx_d = 4'd0;
                end
            end
            APPLY: begin
                if (cnt_q == 8'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SAMPLE: begin
                tt_d = {tt_q[14:0], bus.gate_out};
                // Vector v lives at bit 15-v, i.e. index ~v for a 4-bit v.
                if (!mm_vld_q && (bus.gate_out != EXPECTED_TT[~vec_q])) begin
                    mm_vld_d = 1'b1;
                    mm_idx_d = vec_q;
                end
                if (vec_q == 4'd15) begin
                    state_d = FINISH;
                end else begin
                    state_d = APPLY;
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = CNT_RELOAD;
                end
            end
            FINISH: begin
                state_d = IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (tt_q == EXPECTED_TT);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            vec_q    <= 4'd0;
            cnt_q    <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            tt_q     <= 16'h0000;
            mm_vld_q <= 1'b0;
            mm_idx_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            vec_q    <= vec_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            tt_q     <= tt_d;
            mm_vld_q <= mm_vld_d;
            mm_idx_q <= mm_idx_d;
        end
    end

    // vec_q is itself the registered gate drive; it only moves on entry to APPLY.
    assign bus.gate_in     = vec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.tt_captured = tt_q;

`ifdef GATE_SWEEP_MISMATCH_EN
    assign bus.first_mm_valid = mm_vld_q;
    assign bus.first_mm_idx   = mm_idx_q;
`else
    logic unused_mm;
    assign unused_mm = mm_vld_q ^ (^mm_idx_q);
`endif
endmodule

// File: tb/tb_gate_tt_sweeper.sv
module tb_gate_tt_sweeper;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int mode4  = 0;
    logic [15:0] exp_tt = 16'h1CBF;

    gate_tt_sweeper_if bus4();
    gate_tt_sweeper_if bus1();

    // 0: correct gate, 1: stuck at 0, 2: stuck at 1
    assign bus4.gate_out = (mode4 == 0) ? exp_tt[~bus4.gate_in] : (mode4 == 2);
    assign bus1.gate_out = exp_tt[~bus1.gate_in];

    gate_tt_sweeper #(.EXPECTED_TT(16'h1CBF), .SETTLE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));
    gate_tt_sweeper #(.EXPECTED_TT(16'h1CBF), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        logic [15:0] tt;
        logic        pass;
        int          cyc;
        logic [3:0]  idx;
        logic        mmv;
    } exp_t;

    exp_t q4[$];
    exp_t q1[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("dut4_done_cycle", cyc, e.cyc);
                chk("dut4_tt", bus4.tt_captured, e.tt);
                chk("dut4_pass", bus4.pass, e.pass);
                chk("dut4_busy_at_done", bus4.busy, 0);
`ifdef GATE_SWEEP_MISMATCH_EN
                chk("dut4_mm_valid", bus4.first_mm_valid, e.mmv);
                if (e.mmv) chk("dut4_mm_idx", bus4.first_mm_idx, e.idx);
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.done === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1_done_cycle", cyc, e.cyc);
                chk("dut1_tt", bus1.tt_captured, e.tt);
                chk("dut1_pass", bus1.pass, e.pass);
            end
        end
    end

    task automatic check_reset4(input string tag);
        chk({tag, "_gate_in"}, bus4.gate_in, 0);
        chk({tag, "_busy"}, bus4.busy, 0);
        chk({tag, "_done"}, bus4.done, 0);
        chk({tag, "_pass"}, bus4.pass, 0);
        chk({tag, "_tt"}, bus4.tt_captured, 0);
`ifdef GATE_SWEEP_MISMATCH_EN
        chk({tag, "_mm_valid"}, bus4.first_mm_valid, 0);
        chk({tag, "_mm_idx"}, bus4.first_mm_idx, 0);
`endif
    endtask

    task automatic wait_idle4();
        int n = 0;
        while (bus4.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL dut4_timeout: busy still %0b after %0d cycles, expected 0", bus4.busy, n);
        end
    endtask

    task automatic sweep4(input int mode, input logic [15:0] tt, input logic p,
                          input logic [3:0] idx, input logic mmv);
        exp_t e;
        mode4 = mode;
        @(negedge clk);
        bus4.start = 1'b1;
        e.tt = tt; e.pass = p; e.idx = idx; e.mmv = mmv;
        e.cyc = cyc + 1 + 81;
        q4.push_back(e);
        @(negedge clk);
        bus4.start = 1'b0;
        chk("dut4_busy_after_start", bus4.busy, 1);
        wait_idle4();
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus4.start = 1'b0;
        bus1.start = 1'b0;
        repeat (3) @(negedge clk);
        check_reset4("reset");
        chk("reset_dut1_busy", bus1.busy, 0);
        rst = 1'b0;

        // correct gate, then stuck-at faults
        sweep4(0, 16'h1CBF, 1'b1, 4'd0, 1'b0);
        chk("gate_in_holds_15", bus4.gate_in, 15);
        repeat (3) @(negedge clk);
        chk("tt_stable_after_done", bus4.tt_captured, 16'h1CBF);
        chk("pass_stable_after_done", bus4.pass, 1);
        sweep4(1, 16'h0000, 1'b0, 4'd3, 1'b1);
        sweep4(2, 16'hFFFF, 1'b0, 4'd0, 1'b1);

        // abort mid-sweep: rst sampled at edge k+40
        mode4 = 0;
        @(negedge clk);
        bus4.start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        bus4.start = 1'b0;
        while (cyc < k + 39) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset4("abort");
        rst = 1'b0;
        repeat (100) @(negedge clk);
        sweep4(0, 16'h1CBF, 1'b1, 4'd0, 1'b0);

        // start and rst together: rst wins
        @(negedge clk);
        bus4.start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("start_rst_busy", bus4.busy, 0);
        bus4.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("start_rst_still_idle", bus4.busy, 0);

        // SETTLE_CYCLES=1 with a start pulse while busy
        @(negedge clk);
        bus1.start = 1'b1;
        k = cyc + 1;
        begin
            exp_t e;
            e.tt = 16'h1CBF; e.pass = 1'b1; e.idx = 4'd0; e.mmv = 1'b0; e.cyc = k + 33;
            q1.push_back(e);
        end
        @(negedge clk);
        bus1.start = 1'b0;
        for (int v = 0; v < 16; v++) begin
            chk("dut1_gate_in_apply", bus1.gate_in, v);
            if (v == 3) bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
            chk("dut1_gate_in_sample", bus1.gate_in, v);
            @(negedge clk);
        end
        repeat (20) @(negedge clk);

        chk("dut4_queue_drained", q4.size(), 0);
        chk("dut1_queue_drained", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
